// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stage indices, FSM encoding and
// the register-zero tag.
package pipe_stall_ctrl_pkg;

    localparam int unsigned STAGE_IF  = 0;
    localparam int unsigned STAGE_ID  = 1;
    localparam int unsigned STAGE_EX  = 2;
    localparam int unsigned STAGE_MEM = 3;
    localparam int unsigned STAGE_WB  = 4;

    localparam logic [0:0] StRun    = 1'b0;
    localparam logic [0:0] StMdBusy = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A source only conflicts with a real destination; r0 is hardwired and never a hazard.
    function automatic logic src_hazard(input logic use_src, input logic [4:0] ra,
                                        input logic [4:0] ex_wra);
        return use_src && (ra == ex_wra) && (ex_wra != REG_ZERO);
    endfunction

endpackage

// File: rtl/stall_tag_pipe.sv
// Dest-register tags and load/mul-div flags carried through ID/EX, EX/MEM and MEM/WB.
// Flush takes precedence over enable so a held stage can still be bubbled.
module stall_tag_pipe
    import pipe_stall_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] id_wra_i,
    input  logic       id_we_i,
    input  logic       id_is_load_i,
    input  logic       id_is_md_i,
    input  logic       id_ex_en_i,
    input  logic       id_ex_flush_i,
    input  logic       ex_mem_en_i,
    input  logic       ex_mem_flush_i,
    input  logic       mem_wb_en_i,
    output logic [4:0] ex_wra_o,
    output logic       ex_is_load_o,
    output logic       ex_is_md_o,
    output logic [4:0] mem_wra_o,
    output logic [4:0] wb_wra_o
);

    logic [4:0] ex_wra_q, ex_wra_d;
    logic       ex_is_load_q, ex_is_load_d;
    logic       ex_is_md_q, ex_is_md_d;
    logic [4:0] mem_wra_q, mem_wra_d;
    logic [4:0] wb_wra_q, wb_wra_d;

    always_comb begin
        ex_wra_d     = ex_wra_q;
        ex_is_load_d = ex_is_load_q;
        ex_is_md_d   = ex_is_md_q;
        mem_wra_d    = mem_wra_q;
        wb_wra_d     = wb_wra_q;

        if (id_ex_flush_i) begin
            ex_wra_d     = REG_ZERO;
            ex_is_load_d = 1'b0;
            ex_is_md_d   = 1'b0;
        end else if (id_ex_en_i) begin
            ex_wra_d     = id_we_i ? id_wra_i : REG_ZERO;
            ex_is_load_d = id_is_load_i;
            ex_is_md_d   = id_is_md_i;
        end

        if (ex_mem_flush_i) begin
            mem_wra_d = REG_ZERO;
        end else if (ex_mem_en_i) begin
            mem_wra_d = ex_wra_q;
        end

        if (mem_wb_en_i) begin
            wb_wra_d = mem_wra_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_wra_q     <= REG_ZERO;
            ex_is_load_q <= 1'b0;
            ex_is_md_q   <= 1'b0;
            mem_wra_q    <= REG_ZERO;
            wb_wra_q     <= REG_ZERO;
        end else begin
            ex_wra_q     <= ex_wra_d;
            ex_is_load_q <= ex_is_load_d;
            ex_is_md_q   <= ex_is_md_d;
            mem_wra_q    <= mem_wra_d;
            wb_wra_q     <= wb_wra_d;
        end
    end

    assign ex_wra_o     = ex_wra_q;
    assign ex_is_load_o = ex_is_load_q;
    assign ex_is_md_o   = ex_is_md_q;
    assign mem_wra_o    = mem_wra_q;
    assign wb_wra_o     = wb_wra_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: resolves hazard causes by priority,
// sequences the mul/div wait and counts stalled cycles.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT  = 64,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [4:0]             i_idWra,
    input  logic                   i_idWe,
    input  logic                   i_idIsLoad,
    input  logic                   i_idIsMd,
    input  logic [4:0]             i_idRa1,
    input  logic [4:0]             i_idRa2,
    input  logic                   i_idUse1,
    input  logic                   i_idUse2,
    input  logic                   i_exBrTaken,
    input  logic                   i_extStall,
    input  logic                   i_mdDone,
    output logic                   o_pcEn,
    output logic                   o_ifIdEn,
    output logic                   o_idExEn,
    output logic                   o_exMemEn,
    output logic                   o_memWbEn,
    output logic                   o_ifIdFlush,
    output logic                   o_idExFlush,
    output logic                   o_exMemFlush,
    output logic                   o_mdStart,
    output logic                   o_mdErr,
    output logic [4:0]             o_exWra,
    output logic [4:0]             o_memWra,
    output logic [4:0]             o_wbWra,
    output logic                   o_exIsLoad,
    output logic [STALL_CNT_W-1:0] o_stallCnt
);

    localparam int unsigned CntW = $clog2(MD_TIMEOUT + 1);

    logic [0:0]             state_q, state_d;
    logic [CntW-1:0]        md_cnt_q, md_cnt_d;
    logic                   md_err_q, md_err_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   ex_is_md;
    logic                   load_use;
    logic                   md_timeout;

    stall_tag_pipe u_tag_pipe (
        .clk            (clk),
        .rstn           (rstn),
        .id_wra_i       (i_idWra),
        .id_we_i        (i_idWe),
        .id_is_load_i   (i_idIsLoad),
        .id_is_md_i     (i_idIsMd),
        .id_ex_en_i     (o_idExEn),
        .id_ex_flush_i  (o_idExFlush),
        .ex_mem_en_i    (o_exMemEn),
        .ex_mem_flush_i (o_exMemFlush),
        .mem_wb_en_i    (o_memWbEn),
        .ex_wra_o       (o_exWra),
        .ex_is_load_o   (o_exIsLoad),
        .ex_is_md_o     (ex_is_md),
        .mem_wra_o      (o_memWra),
        .wb_wra_o       (o_wbWra)
    );

    assign load_use = o_exIsLoad && (src_hazard(i_idUse1, i_idRa1, o_exWra) ||
                                     src_hazard(i_idUse2, i_idRa2, o_exWra));

    // This busy cycle is the MD_TIMEOUT-th one: give up and release like a done.
    assign md_timeout = (md_cnt_q + CntW'(1)) == CntW'(MD_TIMEOUT);

    always_comb begin
        o_pcEn       = 1'b1;
        o_ifIdEn     = 1'b1;
        o_idExEn     = 1'b1;
        o_exMemEn    = 1'b1;
        o_memWbEn    = 1'b1;
        o_ifIdFlush  = 1'b0;
        o_idExFlush  = 1'b0;
        o_exMemFlush = 1'b0;
        o_mdStart    = 1'b0;
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        md_err_d     = md_err_q;

        if (rstn) begin
            if (i_extStall) begin
                o_pcEn    = 1'b0;
                o_ifIdEn  = 1'b0;
                o_idExEn  = 1'b0;
                o_exMemEn = 1'b0;
                o_memWbEn = 1'b0;
            end else if (state_q == StMdBusy) begin
                if (i_mdDone || md_timeout) begin
                    state_d  = StRun;
                    md_cnt_d = '0;
                    if (!i_mdDone) begin
                        md_err_d = 1'b1;
                    end
                end else begin
                    // Hold the mul/div op in EX and drain everything behind it.
                    o_pcEn       = 1'b0;
                    o_ifIdEn     = 1'b0;
                    o_idExEn     = 1'b0;
                    o_exMemEn    = 1'b0;
                    o_exMemFlush = 1'b1;
                    md_cnt_d     = md_cnt_q + CntW'(1);
                end
            end else if (ex_is_md) begin
                o_pcEn       = 1'b0;
                o_ifIdEn     = 1'b0;
                o_idExEn     = 1'b0;
                o_exMemEn    = 1'b0;
                o_exMemFlush = 1'b1;
                o_mdStart    = 1'b1;
                state_d      = StMdBusy;
                md_cnt_d     = '0;
            end else if (i_exBrTaken) begin
                o_ifIdFlush = 1'b1;
                o_idExFlush = 1'b1;
            end else if (load_use) begin
                o_pcEn      = 1'b0;
                o_ifIdEn    = 1'b0;
                o_idExFlush = 1'b1;
            end
        end
    end

    assign stall_cnt_d = (!o_pcEn && (stall_cnt_q != '1)) ?
                         stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StRun;
            md_cnt_q    <= '0;
            md_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            md_err_q    <= md_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_mdErr    = md_err_q;
    assign o_stallCnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: decision table, multi-cycle mul/div and reset sequences, then
// random traffic against an action-level pipeline model.
module tb_pipe_stall_ctrl;

    localparam int unsigned MdTimeout = 8;
    localparam int unsigned SatW      = 4;

    logic       clk;
    logic       rstn;
    logic [4:0] i_idWra, i_idRa1, i_idRa2;
    logic       i_idWe, i_idIsLoad, i_idIsMd, i_idUse1, i_idUse2;
    logic       i_exBrTaken, i_extStall, i_mdDone;

    logic        o_pcEn, o_ifIdEn, o_idExEn, o_exMemEn, o_memWbEn;
    logic        o_ifIdFlush, o_idExFlush, o_exMemFlush, o_mdStart, o_mdErr, o_exIsLoad;
    logic [4:0]  o_exWra, o_memWra, o_wbWra;
    logic [31:0] o_stallCnt;

    logic            s_pcEn, s_ifIdEn, s_idExEn, s_exMemEn, s_memWbEn;
    logic            s_ifIdFlush, s_idExFlush, s_exMemFlush, s_mdStart, s_mdErr, s_exIsLoad;
    logic [4:0]      s_exWra, s_memWra, s_wbWra;
    logic [SatW-1:0] s_stallCnt;

    int total = 0;
    int bad   = 0;

    pipe_stall_ctrl #(.MD_TIMEOUT(MdTimeout), .STALL_CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .i_idWra(i_idWra), .i_idWe(i_idWe), .i_idIsLoad(i_idIsLoad),
        .i_idIsMd(i_idIsMd), .i_idRa1(i_idRa1), .i_idRa2(i_idRa2), .i_idUse1(i_idUse1),
        .i_idUse2(i_idUse2), .i_exBrTaken(i_exBrTaken), .i_extStall(i_extStall),
        .i_mdDone(i_mdDone), .o_pcEn(o_pcEn), .o_ifIdEn(o_ifIdEn), .o_idExEn(o_idExEn),
        .o_exMemEn(o_exMemEn), .o_memWbEn(o_memWbEn), .o_ifIdFlush(o_ifIdFlush),
        .o_idExFlush(o_idExFlush), .o_exMemFlush(o_exMemFlush), .o_mdStart(o_mdStart),
        .o_mdErr(o_mdErr), .o_exWra(o_exWra), .o_memWra(o_memWra), .o_wbWra(o_wbWra),
        .o_exIsLoad(o_exIsLoad), .o_stallCnt(o_stallCnt)
    );

    // Narrow counter copy, used only to see saturation.
    pipe_stall_ctrl #(.MD_TIMEOUT(MdTimeout), .STALL_CNT_W(SatW)) dut_sat (
        .clk(clk), .rstn(rstn), .i_idWra(i_idWra), .i_idWe(i_idWe), .i_idIsLoad(i_idIsLoad),
        .i_idIsMd(i_idIsMd), .i_idRa1(i_idRa1), .i_idRa2(i_idRa2), .i_idUse1(i_idUse1),
        .i_idUse2(i_idUse2), .i_exBrTaken(i_exBrTaken), .i_extStall(i_extStall),
        .i_mdDone(i_mdDone), .o_pcEn(s_pcEn), .o_ifIdEn(s_ifIdEn), .o_idExEn(s_idExEn),
        .o_exMemEn(s_exMemEn), .o_memWbEn(s_memWbEn), .o_ifIdFlush(s_ifIdFlush),
        .o_idExFlush(s_idExFlush), .o_exMemFlush(s_exMemFlush), .o_mdStart(s_mdStart),
        .o_mdErr(s_mdErr), .o_exWra(s_exWra), .o_memWra(s_memWra), .o_wbWra(s_wbWra),
        .o_exIsLoad(s_exIsLoad), .o_stallCnt(s_stallCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct packed { logic [4:0] wra; logic load; logic md; } slot_t;
    typedef enum int { ActGo, ActBranch, ActBubble, ActFreeze, ActMdStart, ActMdHold,
                       ActRelease, ActReleaseErr } act_t;
    typedef struct packed {
        logic pc; logic ifid; logic idex; logic exmem; logic memwb;
        logic ififl; logic idexfl; logic exmemfl; logic start;
    } ctl_t;

    bit         m_busy;
    int         m_busy_cycles;
    bit         m_err;
    slot_t      m_ex;
    logic [4:0] m_mem, m_wb;
    int         m_stalls;

    function automatic act_t model_action();
        bit hazard;
        hazard = m_ex.load && (m_ex.wra != 5'd0) &&
                 ((i_idUse1 && i_idRa1 == m_ex.wra) || (i_idUse2 && i_idRa2 == m_ex.wra));
        if (i_extStall) return ActFreeze;
        if (m_busy) begin
            if (i_mdDone) return ActRelease;
            if (m_busy_cycles + 1 == int'(MdTimeout)) return ActReleaseErr;
            return ActMdHold;
        end
        if (m_ex.md) return ActMdStart;
        if (i_exBrTaken) return ActBranch;
        if (hazard) return ActBubble;
        return ActGo;
    endfunction

    function automatic ctl_t ctl_of(input act_t a);
        ctl_t c;
        c = '0;
        case (a)
            ActFreeze: ;
            ActMdStart, ActMdHold: begin
                c.memwb   = 1'b1;
                c.exmemfl = 1'b1;
                c.start   = (a == ActMdStart);
            end
            ActBubble: begin
                {c.idex, c.exmem, c.memwb} = 3'b111;
                c.idexfl = 1'b1;
            end
            ActBranch: begin
                {c.pc, c.ifid, c.idex, c.exmem, c.memwb} = 5'b11111;
                c.ififl  = 1'b1;
                c.idexfl = 1'b1;
            end
            default: {c.pc, c.ifid, c.idex, c.exmem, c.memwb} = 5'b11111;
        endcase
        return c;
    endfunction

    task automatic advance(input slot_t nxt);
        m_wb  = m_mem;
        m_mem = m_ex.wra;
        m_ex  = nxt;
    endtask

    task automatic model_reset();
        m_busy = 0; m_busy_cycles = 0; m_err = 0;
        m_ex = '0; m_mem = '0; m_wb = '0; m_stalls = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with inputs set: checks at negedge, then advances one clock.
    task automatic step();
        act_t  a;
        ctl_t  c;
        slot_t id;
        int    sat;
        @(negedge clk);
        a   = model_action();
        c   = ctl_of(a);
        sat = (m_stalls > 15) ? 15 : m_stalls;
        chk("pcEn", 32'(o_pcEn), 32'(c.pc));
        chk("ifIdEn", 32'(o_ifIdEn), 32'(c.ifid));
        chk("idExEn", 32'(o_idExEn), 32'(c.idex));
        chk("exMemEn", 32'(o_exMemEn), 32'(c.exmem));
        chk("memWbEn", 32'(o_memWbEn), 32'(c.memwb));
        chk("ifIdFlush", 32'(o_ifIdFlush), 32'(c.ififl));
        chk("idExFlush", 32'(o_idExFlush), 32'(c.idexfl));
        chk("exMemFlush", 32'(o_exMemFlush), 32'(c.exmemfl));
        chk("mdStart", 32'(o_mdStart), 32'(c.start));
        chk("exWra", 32'(o_exWra), 32'(m_ex.wra));
        chk("exIsLoad", 32'(o_exIsLoad), 32'(m_ex.load));
        chk("memWra", 32'(o_memWra), 32'(m_mem));
        chk("wbWra", 32'(o_wbWra), 32'(m_wb));
        chk("mdErr", 32'(o_mdErr), 32'(m_err));
        chk("stallCnt", o_stallCnt, 32'(m_stalls));
        chk("stallCntSat", 32'(s_stallCnt), 32'(sat));

        id.wra  = i_idWe ? i_idWra : 5'd0;
        id.load = i_idIsLoad;
        id.md   = i_idIsMd;
        case (a)
            ActFreeze: ;
            ActMdStart: begin
                m_busy = 1; m_busy_cycles = 0; m_wb = m_mem; m_mem = 5'd0;
            end
            ActMdHold: begin
                m_busy_cycles++; m_wb = m_mem; m_mem = 5'd0;
            end
            ActRelease, ActReleaseErr: begin
                m_busy = 0;
                if (a == ActReleaseErr) m_err = 1;
                advance(id);
            end
            ActGo: advance(id);
            default: advance('0);
        endcase
        if (!c.pc) m_stalls++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] wra, input logic we, input logic ld, input logic md,
                          input logic [4:0] ra1, input logic u1, input logic [4:0] ra2,
                          input logic u2);
        i_idWra = wra; i_idWe = we; i_idIsLoad = ld; i_idIsMd = md;
        i_idRa1 = ra1; i_idUse1 = u1; i_idRa2 = ra2; i_idUse2 = u2;
    endtask

    task automatic idle_inputs();
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        i_exBrTaken = 0; i_extStall = 0; i_mdDone = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        #2;
        chk("rst_pcEn", 32'(o_pcEn), 32'd1);
        chk("rst_enables", 32'({o_ifIdEn, o_idExEn, o_exMemEn, o_memWbEn}), 32'hf);
        chk("rst_tags", 32'({o_exWra, o_memWra, o_wbWra}), 32'd0);
        chk("rst_mdErr", 32'(o_mdErr), 32'd0);
        chk("rst_stallCnt", o_stallCnt, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [4:0] p_wra; logic p_load;
        logic [4:0] ra1; logic u1; logic [4:0] ra2; logic u2; logic br;
        logic e_pc; logic e_ififl; logic e_idexfl;
    } vec_t;

    vec_t vecs[8];
    int   starts, frozen, err_at;
    logic [4:0] exh[10], memh[10], wbh[10];

    initial begin
        rstn = 1'b1;
        idle_inputs();
        //            prev       ID srcs                          br   pc  ifFl idFl
        vecs[0] = '{5'd3, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{5'd3, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{5'd9, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{5'd4, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{5'd3, 1'b1, 5'd3, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        #1;
        do_reset();

        // Decision table: previous op goes to EX, then check the decision for the ID op.
        for (int i = 0; i < 8; i++) begin
            set_id(vecs[i].p_wra, 1'b1, vecs[i].p_load, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
            i_exBrTaken = 0;
            step();
            set_id(5'd20, 1'b1, 1'b0, 1'b0, vecs[i].ra1, vecs[i].u1, vecs[i].ra2, vecs[i].u2);
            i_exBrTaken = vecs[i].br;
            #3;
            chk($sformatf("vec%0d_pcEn", i), 32'(o_pcEn), 32'(vecs[i].e_pc));
            chk($sformatf("vec%0d_ifIdFlush", i), 32'(o_ifIdFlush), 32'(vecs[i].e_ififl));
            chk($sformatf("vec%0d_idExFlush", i), 32'(o_idExFlush), 32'(vecs[i].e_idexfl));
            step();
            idle_inputs();
            step();
        end

        // lw $3; add $4,$3,$5: one bubble, then the add proceeds.
        do_reset();
        set_id(5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_id(5'd4, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 5'd5, 1'b1);
        step();
        chk("lu_exWra_bubble", 32'(o_exWra), 32'd0);
        chk("lu_stallCnt", o_stallCnt, 32'd1);
        #3;
        chk("lu_pcEn_after", 32'(o_pcEn), 32'd1);
        step();
        chk("lu_exWra_add", 32'(o_exWra), 32'd4);

        // mul in EX, done 5 cycles after the start pulse.
        do_reset();
        set_id(5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_id(5'd6, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_id(5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        starts = 0; frozen = 0;
        for (int i = 0; i < 10; i++) begin
            i_mdDone = (i == 5);
            #3;
            exh[i] = o_exWra; memh[i] = o_memWra; wbh[i] = o_wbWra;
            if (o_mdStart) starts++;
            if (!o_pcEn && o_exMemFlush) frozen++;
            step();
        end
        i_mdDone = 0;
        chk("md_starts", 32'(starts), 32'd1);
        chk("md_frozen", 32'(frozen), 32'd5);
        chk("md_drain_wb_prior", 32'(wbh[1]), 32'd5);
        chk("md_drain_wb_zero", 32'(wbh[2]), 32'd0);
        chk("md_resume_ex", 32'(exh[6]), 32'd7);
        chk("md_resume_mem", 32'(memh[6]), 32'd6);
        chk("md_resume_wb", 32'(wbh[7]), 32'd6);

        // Timeout without done.
        do_reset();
        set_id(5'd9, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_id(5'd10, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        frozen = 0; err_at = -1;
        for (int i = 0; i < 12; i++) begin
            #3;
            if (!o_pcEn) frozen++;
            if (o_mdErr && err_at < 0) err_at = i;
            step();
        end
        chk("to_frozen", 32'(frozen), 32'd8);
        chk("to_err_cycle", 32'(err_at), 32'd9);
        chk("to_err_sticky", 32'(o_mdErr), 32'd1);
        chk("to_advanced", 32'(o_exWra), 32'd10);

        // extStall for 3 cycles during busy freezes the timeout count.
        do_reset();
        set_id(5'd9, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_id(5'd11, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        frozen = 0; err_at = -1;
        for (int i = 0; i < 16; i++) begin
            i_extStall = (i >= 3 && i <= 5);
            #3;
            if (!o_pcEn) frozen++;
            if (o_mdErr && err_at < 0) err_at = i;
            step();
        end
        i_extStall = 0;
        chk("xs_frozen", 32'(frozen), 32'd11);
        chk("xs_err_cycle", 32'(err_at), 32'd12);

        // Reset in the middle of a busy period.
        set_id(5'd12, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_id(5'd13, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        step();
        rstn = 1'b0;
        #1;
        chk("mr_tags", 32'({o_exWra, o_memWra, o_wbWra}), 32'd0);
        chk("mr_mdErr", 32'(o_mdErr), 32'd0);
        chk("mr_pcEn", 32'(o_pcEn), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("mr_no_start", 32'(o_mdStart), 32'd0);
            chk("mr_run_pcEn", 32'(o_pcEn), 32'd1);
            step();
        end

        // Random traffic.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            set_id(5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                   1'b0, 1'b0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4: i_idIsLoad = 1'b1;
                5:             i_idIsMd = 1'b1;
                default: ;
            endcase
            i_exBrTaken = ($urandom_range(0, 99) < 15);
            i_extStall  = ($urandom_range(0, 99) < 10);
            i_mdDone    = ($urandom_range(0, 99) < 15);
            step();
        end

        // Long external stall drives the narrow counter into saturation.
        idle_inputs();
        i_extStall = 1;
        for (int i = 0; i < 20; i++) step();
        i_extStall = 0;
        chk("sat_value", 32'(s_stallCnt), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
